tweet_tx: RTL and testbench

Buffered 8N1 UART transmitter. It is the transmit end of the serial link that the tweetboard receive path samples. Upstream logic (RAM replay or keyboard echo) pushes bytes into an internal FIFO, and the block serialises them back-to-back on a registered, idle-high line. It replaces the single-byte start/data transmit path wherever queued output is needed.

---
 rtl/tweet_tx.sv | 151 +++++++++++++++
 tb/tb_tweet_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tweet_tx.sv
// tweet_tx: buffered 8N1 UART transmitter.
// A small FIFO feeds a start/data/stop serialiser with a registered idle-high line.
module tweet_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [7:0]        data_in,
    input  logic              hold,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic [ADDR_W:0]    count_nxt;
    logic [7:0]         shift;
    logic [7:0]         head;
    logic [BAUD_W-1:0]  baud;
    logic [2:0]         bit_idx;
    logic               last;
    logic               push;
    logic               pop;

    assign last = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign head = mem[rd_ptr[ADDR_W-1:0]];

    // A pop only happens when the FSM is ready to launch a new start bit.
    always_comb begin
        push = wr_en && !full;
        pop  = !empty && !hold &&
               ((state == IDLE) || ((state == STOP) && last));
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= head;
                        tx    <= 1'b0;
                        baud  <= '0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (last) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tweet_tx.sv
// Directed testbench for tweet_tx with a 4-cycle bit time and a 4-deep FIFO.
// Each scenario task drives stimulus and checks its own expected values.
module tb_tweet_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          sysclk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [7:0]    data_in;
    logic          hold;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    tweet_tx #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .sysclk(sysclk),
        .reset_n(reset_n),
        .wr_en(wr_en),
        .data_in(data_in),
        .hold(hold),
        .tx(tx),
        .busy(busy),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Decodes one frame. With do_wait the start edge is searched for;
    // otherwise the caller is already at cycle 'offset' of a start bit.
    task automatic capture_frame(input bit do_wait, input int offset,
                                 output logic [7:0] b, output int gap);
        int off;
        bit found;
        b     = 8'h00;
        gap   = 0;
        off   = offset;
        found = !do_wait;
        if (do_wait) begin
            for (int i = 0; i < 200; i++) begin
                tick();
                gap++;
                if (tx === 1'b0) begin
                    found = 1'b1;
                    break;
                end
            end
            off = 0;
        end
        checks++;
        if (!found) begin
            $display("FAIL frame_start_timeout tx=%b wanted 0 within 200 cycles", tx);
            errors++;
        end else begin
            repeat (2 - off) tick();
            checks++;
            if (tx !== 1'b0) begin
                $display("FAIL start_bit tx=%b wanted 0", tx);
                errors++;
            end
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) tick();
                b[i] = tx;
            end
            repeat (CPB) tick();
            checks++;
            if (tx !== 1'b1) begin
                $display("FAIL stop_bit tx=%b wanted 1", tx);
                errors++;
            end
            tick();
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        data_in = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_en   = 1'b0;
        data_in = 8'h00;
        hold    = 1'b0;
        #12;
        checks++;
        if ({tx, busy, full, empty, count, overflow} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            $display("FAIL reset_state tx=%b busy=%b full=%b empty=%b count=%0d ovf=%b wanted 1 0 0 1 0 0",
                     tx, busy, full, empty, count, overflow);
            errors++;
        end
        #2 reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single();
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        write_byte(8'h55);
        checks++;
        if (count !== 3'd1 || tx !== 1'b1) begin
            $display("FAIL single_write count=%0d tx=%b wanted 1 1", count, tx);
            errors++;
        end
        tick();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || count !== 3'd0) begin
            $display("FAIL single_latency tx=%b busy=%b count=%0d wanted 0 1 0", tx, busy, count);
            errors++;
        end
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i > 0) tick();
            checks++;
            if (tx !== fr[i / CPB] || busy !== 1'b1) begin
                $display("FAIL single_line cyc=%0d tx=%b busy=%b wanted %b 1", i, tx, busy, fr[i / CPB]);
                errors++;
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            $display("FAIL single_idle busy=%b tx=%b wanted 0 1", busy, tx);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int gap;
        write_byte(8'h41);
        checks++;
        if (count !== 3'd1) begin
            $display("FAIL b2b_count0 count=%0d wanted 1", count);
            errors++;
        end
        write_byte(8'h42);
        checks++;
        if (count !== 3'd1 || tx !== 1'b0) begin
            $display("FAIL b2b_count1 count=%0d tx=%b wanted 1 0", count, tx);
            errors++;
        end
        write_byte(8'h43);
        checks++;
        if (count !== 3'd2) begin
            $display("FAIL b2b_count2 count=%0d wanted 2", count);
            errors++;
        end
        capture_frame(1'b0, 1, b, gap);
        checks++;
        if (b !== 8'h41) begin
            $display("FAIL b2b_byte0 got=%h wanted 41", b);
            errors++;
        end
        capture_frame(1'b1, 0, b, gap);
        checks++;
        if (b !== 8'h42 || gap !== 1) begin
            $display("FAIL b2b_byte1 got=%h gap=%0d wanted 42 1", b, gap);
            errors++;
        end
        capture_frame(1'b1, 0, b, gap);
        checks++;
        if (b !== 8'h43 || gap !== 1) begin
            $display("FAIL b2b_byte2 got=%h gap=%0d wanted 43 1", b, gap);
            errors++;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || empty !== 1'b1) begin
            $display("FAIL b2b_idle busy=%b tx=%b empty=%b wanted 0 1 1", busy, tx, empty);
            errors++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int gap;
        hold = 1'b1;
        for (int i = 1; i <= 4; i++)
            write_byte(8'(i));
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL ovf_full full=%b count=%0d ovf=%b busy=%b wanted 1 4 0 0", full, count, overflow, busy);
            errors++;
        end
        write_byte(8'h05);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            $display("FAIL ovf_flag ovf=%b count=%0d wanted 1 4", overflow, count);
            errors++;
        end
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            capture_frame(1'b1, 0, b, gap);
            checks++;
            if (b !== 8'(i) || gap !== 1) begin
                $display("FAIL ovf_byte%0d got=%h gap=%0d wanted %h 1", i, b, gap, 8'(i));
                errors++;
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) begin
            $display("FAIL ovf_end busy=%b empty=%b ovf=%b wanted 0 1 1", busy, empty, overflow);
            errors++;
        end
    endtask

    task automatic test_hold();
        logic [7:0] b;
        int gap;
        write_byte(8'h3C);
        write_byte(8'hC3);
        repeat (17) tick();
        hold = 1'b1;
        checks++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            $display("FAIL hold_mid busy=%b tx=%b wanted 1 1", busy, tx);
            errors++;
        end
        repeat (23) tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || count !== 3'd1) begin
            $display("FAIL hold_idle busy=%b tx=%b count=%0d wanted 0 1 1", busy, tx, count);
            errors++;
        end
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            $display("FAIL hold_stay busy=%b tx=%b wanted 0 1", busy, tx);
            errors++;
        end
        hold = 1'b0;
        tick();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || count !== 3'd0) begin
            $display("FAIL hold_release tx=%b busy=%b count=%0d wanted 0 1 0", tx, busy, count);
            errors++;
        end
        capture_frame(1'b0, 0, b, gap);
        checks++;
        if (b !== 8'hC3) begin
            $display("FAIL hold_byte got=%h wanted c3", b);
            errors++;
        end
        tick();
    endtask

    task automatic test_push_pop();
        logic [7:0] b;
        int gap;
        write_byte(8'h5A);
        write_byte(8'hA5);
        repeat (39) tick();
        checks++;
        if (count !== 3'd1 || tx !== 1'b1) begin
            $display("FAIL pp_pre count=%0d tx=%b wanted 1 1", count, tx);
            errors++;
        end
        write_byte(8'h99);
        checks++;
        if (count !== 3'd1 || tx !== 1'b0) begin
            $display("FAIL pp_count count=%0d tx=%b wanted 1 0", count, tx);
            errors++;
        end
        capture_frame(1'b0, 0, b, gap);
        checks++;
        if (b !== 8'hA5) begin
            $display("FAIL pp_byte0 got=%h wanted a5", b);
            errors++;
        end
        capture_frame(1'b1, 0, b, gap);
        checks++;
        if (b !== 8'h99 || gap !== 1) begin
            $display("FAIL pp_byte1 got=%h gap=%0d wanted 99 1", b, gap);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int gap;
        hold = 1'b1;
        for (int i = 0; i < 5; i++)
            write_byte(8'hF0);
        hold = 1'b0;
        tick();
        repeat (25) tick();
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b1) begin
            $display("FAIL rst_pre busy=%b ovf=%b wanted 1 1", busy, overflow);
            errors++;
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, count, overflow, empty} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            $display("FAIL rst_async tx=%b busy=%b count=%0d ovf=%b empty=%b wanted 1 0 0 0 1",
                     tx, busy, count, overflow, empty);
            errors++;
        end
        #1 reset_n = 1'b1;
        tick();
        write_byte(8'h7E);
        capture_frame(1'b1, 0, b, gap);
        checks++;
        if (b !== 8'h7E || gap !== 1) begin
            $display("FAIL rst_byte got=%h gap=%0d wanted 7e 1", b, gap);
            errors++;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            $display("FAIL rst_idle busy=%b tx=%b wanted 0 1", busy, tx);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_hold();
        test_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
